muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit, sitting directly downstream of operand preparation.
- Consumes the prepared operand pair (rs1 path, rs2 path) when the decoded instruction is an M-extension op (opcode OP, funct7 = 0000001).
- Computes over multiple cycles and returns a 32-bit result through a start/busy/done handshake. The core holds writeback until done.

---
 rtl/muldiv_unit.sv | 159 +++++++++++++++
 tb/tb_muldiv_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a start/busy/done handshake and pipeline flush.
module muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] data_alu1,
    input  logic [XLEN-1:0] data_alu2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned W2 = 2 * XLEN;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [W2-1:0]   r_acc;
    logic [XLEN-1:0] r_opnd;
    logic            r_is_div;
    logic            r_sel;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_busy;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    // Operand decode: signedness, magnitudes and special cases seen in IDLE
    logic            w_a_sgn;
    logic            w_b_sgn;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN-1:0] w_spec_res;

    assign w_a_sgn = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign w_b_sgn = funct3[2] ? ~funct3[0] : ~funct3[1];
    assign w_a_neg = w_a_sgn & data_alu1[XLEN-1];
    assign w_b_neg = w_b_sgn & data_alu2[XLEN-1];
    assign w_a_mag = w_a_neg ? (~data_alu1 + XLEN'(1)) : data_alu1;
    assign w_b_mag = w_b_neg ? (~data_alu2 + XLEN'(1)) : data_alu2;
    assign w_div0  = funct3[2] && (data_alu2 == '0);
    assign w_ovf   = funct3[2] && !funct3[0]
                     && (data_alu1 == {1'b1, {(XLEN-1){1'b0}}})
                     && (data_alu2 == '1);
    assign w_spec_res = w_div0 ? (funct3[1] ? data_alu1 : '1)
                               : (funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

    // Multiply step: add multiplicand into the high half, shift right
    logic [XLEN:0]   w_mul_sum;
    assign w_mul_sum = {1'b0, r_acc[W2-1:XLEN]} + {1'b0, (r_acc[0] ? r_opnd : '0)};

    // Divide step: shift partial remainder left and trial-subtract the divisor
    logic [XLEN:0]   w_div_hi;
    logic            w_div_ge;
    logic [XLEN-1:0] w_div_diff;
    assign w_div_hi   = r_acc[W2-2:XLEN-1];
    assign w_div_ge   = (w_div_hi >= {1'b0, r_opnd});
    assign w_div_diff = XLEN'(w_div_hi - {1'b0, r_opnd});

    // Sign correction and word selection
    logic [W2-1:0]   w_prod;
    logic [XLEN-1:0] w_quo;
    logic [XLEN-1:0] w_rem;
    logic [XLEN-1:0] w_fix_res;
    assign w_prod    = r_neg_q ? (~r_acc + W2'(1)) : r_acc;
    assign w_quo     = r_neg_q ? (~r_acc[XLEN-1:0] + XLEN'(1)) : r_acc[XLEN-1:0];
    assign w_rem     = r_neg_r ? (~r_acc[W2-1:XLEN] + XLEN'(1)) : r_acc[W2-1:XLEN];
    assign w_fix_res = r_is_div ? (r_sel ? w_rem : w_quo)
                                : (r_sel ? w_prod[W2-1:XLEN] : w_prod[XLEN-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_is_div <= 1'b0;
            r_sel    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (flush && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_busy   <= 1'b1;
                        r_is_div <= funct3[2];
                        r_sel    <= funct3[2] ? funct3[1] : (funct3[1:0] != 2'b00);
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_opnd   <= funct3[2] ? w_b_mag : w_a_mag;
                        r_acc    <= {{XLEN{1'b0}}, (funct3[2] ? w_a_mag : w_b_mag)};
                        r_cnt    <= '0;
                        if (w_div0 || w_ovf) begin
                            r_result <= w_spec_res;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (r_is_div) begin
                        r_acc <= {(w_div_ge ? w_div_diff : w_div_hi[XLEN-1:0]),
                                  r_acc[XLEN-2:0], w_div_ge};
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(XLEN - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected result and done cycle are queued at
// issue and retired by a monitor when done pulses.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] data_alu1;
    logic [31:0] data_alu2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          due;
        string       tag;
    } exp_t;

    exp_t scb[$];
    int   cyc;
    int   n_chk;
    int   n_err;

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct3    (funct3),
        .data_alu1 (data_alu1),
        .data_alu2 (data_alu2),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Monitor: retire one scoreboard entry per done pulse
    always @(negedge clk) begin
        if (done) begin
            if (scb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = scb.pop_front();
                check(e.tag, result, e.res);
                check({e.tag, "_cycle"}, 32'(cyc), 32'(e.due));
            end
        end
    end

    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] sa, sbv, ua, ub, p;
        int          ia, ib;
        logic [31:0] r;
        sa  = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ia  = a;
        ib  = b;
        p   = '0;
        r   = '0;
        case (f3)
            3'd0: begin p = sa * sbv; r = p[31:0]; end
            3'd1: begin p = sa * sbv; r = p[63:32]; end
            3'd2: begin p = sa * ub;  r = p[63:32]; end
            3'd3: begin p = ua * ub;  r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFFFFFF :
                      ((a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(ia / ib));
            3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: r = (b == 0) ? a :
                      ((a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'd0 : 32'(ia % ib));
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
            return 1;
        return 34;
    endfunction

    // Wait until the scoreboard drains, counting busy cycles
    task automatic wait_drain(output int bc);
        bc = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (busy) bc++;
            if (scb.size() == 0) return;
        end
        check("drain_timeout", 32'd1, 32'd0);
        scb.delete();
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input string tag);
        exp_t e;
        @(negedge clk);
        start     = 1'b1;
        funct3    = f3;
        data_alu1 = a;
        data_alu2 = b;
        e.res = exp;
        e.due = cyc + lat;
        e.tag = tag;
        scb.push_back(e);
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string tag);
        int bc;
        issue(f3, a, b, exp, lat, tag);
        wait_drain(bc);
        check({tag, "_busy"}, 32'(bc), 32'(lat));
    endtask

    initial begin
        int          bc;
        logic [31:0] held;
        logic [2:0]  f3;
        logic [31:0] a, b;
        n_chk = 0;
        n_err = 0;
        cyc   = 0;
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = '0; data_alu1 = '0; data_alu2 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul");
        run_op(3'd1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34, "mulh");
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34, "mulhsu");
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 34, "mulhu");
        run_op(3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34, "div");
        run_op(3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34, "rem");
        run_op(3'd5, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 34, "divu");
        run_op(3'd4, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1, "div0");
        run_op(3'd7, 32'h12345678, 32'h00000000, 32'h12345678, 1, "remu0");
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, "rem_ovf");

        // Input changes and a second start while busy must not disturb the op
        issue(3'd5, 32'd100, 32'd7, 32'd14, 34, "divu_latch");
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 5) data_alu1 = 32'd999;
            if (k == 10) begin
                start = 1'b1; funct3 = 3'd0; data_alu1 = 32'd3; data_alu2 = 32'd5;
            end
        end
        wait_drain(bc);
        check("divu_latch_busy", 32'(bc + 10), 32'd34);
        repeat (40) @(negedge clk);

        // Flush mid-MULHU
        held = result;
        @(negedge clk);
        start = 1'b1; funct3 = 3'd3; data_alu1 = 32'hFFFFFFFF; data_alu2 = 32'hFFFFFFFF;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        check("flush_result", result, held);
        repeat (40) @(negedge clk);
        check("flush_result_hold", result, held);

        // Asynchronous reset mid-DIV
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; data_alu1 = 32'd1000; data_alu2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Random ops against the reference model
        for (int i = 0; i < 12; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (i % 4 == 0) ? 32'd0 : $urandom;
            run_op(f3, a, b, ref_md(f3, a, b), ref_lat(f3, a, b), $sformatf("rand%0d", i));
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
